herald_engine_arbiter: RTL and testbench
========================================

Name: herald_engine_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one arithmetic engine (the CORDIC or MAC unit, using the start/busy/get method interface) between two command requesters.
- Accepts one command at a time and runs start -> wait-not-busy -> get on the engine.
- Returns the result, or a timeout error, to the requester that issued the command.
- Sits between the host byte-protocol front end and a second internal client, such as a test sequencer, and the engine.

Parameters:
DATA_W, 24, operand width (Q12.12)
RES_W, 72, result width (holds up to 3x24-bit packed results)
TIMEOUT, 255, max cycles spent in WAIT+GET before aborting; legal range 2..255
NORES_OP, 3'd7, op code with no result (accumulator clear); skips WAIT/GET

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_op  in  3  requester 0 engine op code
req0_a  in  DATA_W  requester 0 operand A
req0_b  in  DATA_W  requester 0 operand B
req1_valid/req1_ready/req1_op/req1_a/req1_b  same as requester 0
rsp0_valid  out  1  response valid to requester 0
rsp0_ready  in  1  requester 0 takes response
rsp0_data  out  RES_W  result for requester 0
rsp0_err  out  1  timeout flag for requester 0
rsp1_valid/rsp1_ready/rsp1_data/rsp1_err  same as requester 0
eng_op  out  3  latched op to engine
eng_a  out  DATA_W  latched operand A
eng_b  out  DATA_W  latched operand B
eng_start  out  1  one-cycle start pulse
eng_busy  in  1  engine busy
eng_get  out  1  result fetch enable
eng_res_valid  in  1  engine result ready (RDY_get)
eng_res  in  RES_W  engine result

Behaviour:
- Reset, asynchronous, while rst=1:
  - state=IDLE, last_grant=1 (so req0 wins the first tie).
  - All outputs 0; op/operand/result/err/timeout registers cleared.
  - Reset mid-operation abandons the command; no response is ever produced for it.
- States: IDLE, ISSUE, WAIT, GET, RESP.
- IDLE:
  - Grant = the only valid requester; if both are valid, the one != last_grant.
  - reqN_ready is combinational: (state==IDLE) && grant==N && reqN_valid. At most one ready is high at a time.
  - On handshake (cycle T): latch op/a/b into eng_op/eng_a/eng_b, store owner=N, set last_grant=N, go to ISSUE.
- ISSUE (T+1):
  - eng_start=1 for exactly this cycle; timeout counter cleared.
  - If op==NORES_OP: go to RESP with data=0, err=0. Otherwise go to WAIT.
- WAIT:
  - The first WAIT cycle ignores eng_busy, giving the engine one cycle to raise it.
  - From the second WAIT cycle, eng_busy=0 moves to GET.
- GET:
  - eng_get=1 while in GET.
  - In a cycle where eng_res_valid=1: capture eng_res, err=0, go to RESP. eng_get is high in that cycle.
- Timeout:
  - Counter increments every cycle in WAIT and GET.
  - When the counter reaches TIMEOUT with no result capture, go to RESP with data=0, err=1 and drop eng_get.
  - Result capture in the same cycle as the counter reaching TIMEOUT: capture wins, err=0.
- RESP:
  - rsp<owner>_valid=1, with data and err held stable until rsp<owner>_ready=1.
  - Handshake cycle -> IDLE. A new request can be accepted on the next cycle at the earliest.
  - The non-owner rsp_valid stays 0.
- Minimum latency, result op with an engine that never raises busy: handshake T, start T+1, WAIT T+2..T+3, GET T+4, rsp_valid T+5.
- eng_op/eng_a/eng_b hold their value from latch until the next accepted request.
- A requester may drop valid before being granted; no side effect.
- Requests arriving outside IDLE see ready=0 and must hold.
- Fairness: under continuous contention, grants alternate 0,1,0,1.

Test Plan:
- Single req0 op=0, a=0x001000, b=0x002000; engine busy for 3 cycles from start, eng_res=72'h123456 -> eng_start is one pulse at T+1; rsp0_valid with data 0x123456, err=0; rsp1_valid stays 0.
- req0 and req1 valid in the same cycle after reset, held continuously, 4 commands -> grant order 0,1,0,1; each response goes only to its issuer.
- req1 op=7 (NORES_OP) -> eng_start pulse, eng_get never asserted, rsp1_valid at T+2 with data 0, err=0.
- TIMEOUT=8, engine busy stuck at 1 -> rsp0_valid with err=1, data 0, 8 cycles after entering WAIT; next request is accepted normally.
- rsp0_ready held low for 10 cycles -> rsp0 data/err stable and both req_ready low the whole time; ready=1 -> IDLE next cycle.
- Assert rst during WAIT -> all outputs 0 immediately (asynchronous); after release, a req1-only request is accepted and a tie is won by req0.

Source files
------------

// File: rtl/herald_engine_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : herald_engine_arbiter_if
// Description : Command/response channel between one requester and the
//               herald engine arbiter. The requester drives the command and
//               takes the response; the arbiter accepts the command and
//               returns the result.
// Revision    : 1.0 - initial release
// ============================================================================
interface herald_engine_arbiter_if #(
  parameter int DATA_W = 24,
  parameter int RES_W  = 72
);
  logic              valid;
  logic              ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_data;
  logic              rsp_err;

  // Requester side: issues commands, consumes responses
  modport master (
    output valid, op, a, b, rsp_ready,
    input  ready, rsp_valid, rsp_data, rsp_err
  );

  // Arbiter side: accepts commands, produces responses
  modport slave (
    input  valid, op, a, b, rsp_ready,
    output ready, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/herald_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : herald_engine_arbiter
// Description : Round-robin arbiter/sequencer sharing one start/busy/get
//               arithmetic engine between two requesters. One command is in
//               flight at a time: start -> wait-not-busy -> get, then the
//               result (or a timeout error) goes back to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module herald_engine_arbiter #(
  parameter int         DATA_W   = 24,
  parameter int         RES_W    = 72,
  parameter int         TIMEOUT  = 255,
  parameter logic [2:0] NORES_OP = 3'd7
) (
  input  logic                   clk,
  input  logic                   rst,
  herald_engine_arbiter_if.slave req0,
  herald_engine_arbiter_if.slave req1,
  output logic [2:0]             eng_op,
  output logic [DATA_W-1:0]      eng_a,
  output logic [DATA_W-1:0]      eng_b,
  output logic                   eng_start,
  input  logic                   eng_busy,
  output logic                   eng_get,
  input  logic                   eng_res_valid,
  input  logic [RES_W-1:0]       eng_res
);

  // --------------------------------------------------------------------------
  // Sequencer states
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_issue = 3'd1;
  localparam logic [2:0] c_st_wait  = 3'd2;
  localparam logic [2:0] c_st_get   = 3'd3;
  localparam logic [2:0] c_st_resp  = 3'd4;

  // Cycle budget for WAIT+GET; the counter is 8 bits since TIMEOUT <= 255
  localparam logic [7:0] c_timeout  = 8'(TIMEOUT);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [RES_W-1:0]  r_data;
  logic              r_err;
  logic [7:0]        r_cnt;
  logic              r_wait_first;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [2:0]        w_state_next;
  logic              w_idle;
  logic              w_grant;
  logic              w_accept;
  logic              w_rsp_take;
  logic [7:0]        w_cnt_inc;
  logic              w_expired;
  logic              w_capture;
  logic              w_abort;
  logic              w_nores_done;
  logic [2:0]        w_sel_op;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;

  // Ready is suppressed during reset so every output reads 0 while rst is high
  assign w_idle = (r_state == c_st_idle) && !rst;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_grant = 1'b0;
    if (req0.valid && req1.valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1.valid;
    end
  end

  assign req0.ready = w_idle && req0.valid && !w_grant;
  assign req1.ready = w_idle && req1.valid &&  w_grant;
  assign w_accept   = req0.ready || req1.ready;

  assign w_sel_op = w_grant ? req1.op : req0.op;
  assign w_sel_a  = w_grant ? req1.a  : req0.a;
  assign w_sel_b  = w_grant ? req1.b  : req0.b;

  // Response completes when the owning requester takes it
  assign w_rsp_take = (r_state == c_st_resp) &&
                      (r_owner ? req1.rsp_ready : req0.rsp_ready);

  // The counter value after this cycle; reaching the budget aborts the command
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_expired = (w_cnt_inc == c_timeout);

  // Next-state decode; a result capture takes priority over an expiring budget
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    w_nores_done = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_next = c_st_issue;
        end
      end
      c_st_issue: begin
        if (r_op == NORES_OP) begin
          w_nores_done = 1'b1;
          w_state_next = c_st_resp;
        end else begin
          w_state_next = c_st_wait;
        end
      end
      c_st_wait: begin
        // The first WAIT cycle gives the engine time to raise busy
        if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = c_st_resp;
        end else if (!r_wait_first && !eng_busy) begin
          w_state_next = c_st_get;
        end
      end
      c_st_get: begin
        if (eng_res_valid) begin
          w_capture    = 1'b1;
          w_state_next = c_st_resp;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = c_st_resp;
        end
      end
      c_st_resp: begin
        if (w_rsp_take) begin
          w_state_next = c_st_idle;
        end
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // State register; reset abandons any command in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch the granted command and remember who owns it for the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= 3'd0;
      r_a          <= '0;
      r_b          <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
      r_owner      <= w_grant;
      r_op         <= w_sel_op;
      r_a          <= w_sel_a;
      r_b          <= w_sel_b;
    end
  end

  // Timeout counter: cleared at start, counts every WAIT and GET cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= 8'd0;
      r_wait_first <= 1'b0;
    end else if (r_state == c_st_issue) begin
      r_cnt        <= 8'd0;
      r_wait_first <= 1'b1;
    end else if ((r_state == c_st_wait) || (r_state == c_st_get)) begin
      r_cnt        <= w_cnt_inc;
      r_wait_first <= 1'b0;
    end
  end

  // Result/error register, held stable for the whole RESP phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_capture) begin
      r_data <= eng_res;
      r_err  <= 1'b0;
    end else if (w_abort) begin
      r_data <= '0;
      r_err  <= 1'b1;
    end else if (w_nores_done) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign eng_op    = r_op;
  assign eng_a     = r_a;
  assign eng_b     = r_b;
  assign eng_start = (r_state == c_st_issue);
  assign eng_get   = (r_state == c_st_get);

  assign req0.rsp_valid = (r_state == c_st_resp) && !r_owner;
  assign req1.rsp_valid = (r_state == c_st_resp) &&  r_owner;
  assign req0.rsp_data  = r_data;
  assign req1.rsp_data  = r_data;
  assign req0.rsp_err   = r_err;
  assign req1.rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_herald_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_herald_engine_arbiter
// Description : Self-checking bench for herald_engine_arbiter. A transaction
//               model predicts, from each accepted command and the engine
//               behaviour chosen for it, the cycles of start/get/response and
//               the returned data; a negedge process compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_herald_engine_arbiter;

  localparam int         DATA_W = 24;
  localparam int         RES_W  = 72;
  localparam int         TO     = 8;
  localparam logic [2:0] NORES  = 3'd7;
  localparam int         NEVER  = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  herald_engine_arbiter_if #(.DATA_W(DATA_W), .RES_W(RES_W)) req0_if ();
  herald_engine_arbiter_if #(.DATA_W(DATA_W), .RES_W(RES_W)) req1_if ();

  logic [2:0]        eng_op;
  logic [DATA_W-1:0] eng_a;
  logic [DATA_W-1:0] eng_b;
  logic              eng_start;
  logic              eng_busy = 1'b0;
  logic              eng_get;
  logic              eng_res_valid = 1'b0;
  logic [RES_W-1:0]  eng_res = '0;

  herald_engine_arbiter #(
    .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TO), .NORES_OP(NORES)
  ) dut (
    .clk(clk), .rst(rst), .req0(req0_if), .req1(req1_if),
    .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
    .eng_start(eng_start), .eng_busy(eng_busy), .eng_get(eng_get),
    .eng_res_valid(eng_res_valid), .eng_res(eng_res)
  );

  // Bookkeeping
  int cyc  = 0;
  int nchk = 0;
  int nbad = 0;
  bit chk_en = 1'b0;

  // Requester intent
  bit                pv [2];
  logic [2:0]        pop [2];
  logic [DATA_W-1:0] pa [2];
  logic [DATA_W-1:0] pb [2];
  bit                rr [2];

  // Engine behaviour for the next accepted command
  int               plan_L;
  int               plan_D;
  logic [RES_W-1:0] plan_res;

  // Transaction model
  bit               act;
  int               own;
  bit               t_nores;
  int               t_T, t_S, t_g, t_R, t_L, t_D;
  logic [RES_W-1:0] t_res, t_data;
  bit               t_err;
  bit               last_g;
  logic [2:0]        m_op;
  logic [DATA_W-1:0] m_a, m_b;
  int               grants [$];

  // Expected outputs for the current cycle
  bit                e_rdy [2];
  bit                e_rv  [2];
  bit                e_start, e_get, e_err;
  logic [RES_W-1:0]  e_data;
  logic [2:0]        e_op;
  logic [DATA_W-1:0] e_a, e_b;

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic chk(input string nm, input logic [RES_W-1:0] got,
                     input logic [RES_W-1:0] want);
    nchk++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, want);
    end
  endtask

  task automatic bound_fail(input string nm);
    nchk++;
    nbad++;
    $display("FAIL %s: cycle budget expired at cycle %0d", nm, cyc);
  endtask

  task automatic model_reset();
    act    = 1'b0;
    last_g = 1'b1;
    m_op   = '0;
    m_a    = '0;
    m_b    = '0;
    pv[0]  = 1'b0;
    pv[1]  = 1'b0;
    t_R    = NEVER;
  endtask

  // Predict the whole timeline of a command accepted in cycle cyc
  task automatic open_txn(input int gr);
    int c;
    int cap;
    own     = gr;
    t_T     = cyc;
    t_S     = cyc + 1;
    t_nores = (pop[gr] == NORES);
    t_L     = plan_L;
    t_D     = plan_D;
    t_res   = plan_res;
    if (t_nores) begin
      t_R    = t_S + 1;
      t_g    = NEVER;
      t_data = '0;
      t_err  = 1'b0;
    end else begin
      // Leave WAIT at the first non-busy cycle after the ignored one
      c   = imax(t_S + 2, t_S + t_L + 1);
      t_g = c + 1;
      // Result shows up D cycles after busy falls; it is taken once in GET
      cap = imax(t_g, t_S + t_L + 1 + t_D);
      if (cap <= t_S + TO) begin
        t_R    = cap + 1;
        t_data = t_res;
        t_err  = 1'b0;
      end else begin
        t_R    = t_S + TO + 1;
        t_data = '0;
        t_err  = 1'b1;
      end
    end
    act = 1'b1;
  endtask

  // Advance one cycle: drive inputs, compute expectations, advance the model
  task automatic step();
    int gr;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();

    req0_if.valid     = pv[0];
    req0_if.op        = pop[0];
    req0_if.a         = pa[0];
    req0_if.b         = pb[0];
    req0_if.rsp_ready = rr[0];
    req1_if.valid     = pv[1];
    req1_if.op        = pop[1];
    req1_if.a         = pa[1];
    req1_if.b         = pb[1];
    req1_if.rsp_ready = rr[1];

    eng_busy      = act && !t_nores && (cyc >= t_S + 1) && (cyc <= t_S + t_L) && (cyc < t_R);
    eng_res_valid = act && !t_nores && (cyc >= t_S + t_L + 1 + t_D) && (cyc < t_R);
    eng_res       = t_res;

    e_start  = act && (cyc == t_S);
    e_get    = act && (cyc >= t_g) && (cyc < t_R);
    e_rv[0]  = act && (cyc >= t_R) && (own == 0);
    e_rv[1]  = act && (cyc >= t_R) && (own == 1);
    e_data   = t_data;
    e_err    = t_err;
    e_op     = m_op;
    e_a      = m_a;
    e_b      = m_b;
    e_rdy[0] = 1'b0;
    e_rdy[1] = 1'b0;
    gr = 0;
    if (!act && !rst && (pv[0] || pv[1])) begin
      gr = (pv[0] && pv[1]) ? int'(!last_g) : (pv[1] ? 1 : 0);
      e_rdy[gr] = 1'b1;
    end

    if (!act && !rst && (pv[0] || pv[1])) begin
      m_op   = pop[gr];
      m_a    = pa[gr];
      m_b    = pb[gr];
      last_g = (gr == 1);
      pv[gr] = 1'b0;
      grants.push_back(gr);
      open_txn(gr);
    end else if (act && (cyc >= t_R) && rr[own]) begin
      act = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req0_ready", req0_if.ready, e_rdy[0]);
      chk("req1_ready", req1_if.ready, e_rdy[1]);
      chk("eng_start", eng_start, e_start);
      chk("eng_get", eng_get, e_get);
      chk("rsp0_valid", req0_if.rsp_valid, e_rv[0]);
      chk("rsp1_valid", req1_if.rsp_valid, e_rv[1]);
      chk("eng_op", eng_op, e_op);
      chk("eng_a", eng_a, e_a);
      chk("eng_b", eng_b, e_b);
      if (e_rv[0]) begin
        chk("rsp0_data", req0_if.rsp_data, e_data);
        chk("rsp0_err", req0_if.rsp_err, e_err);
      end
      if (e_rv[1]) begin
        chk("rsp1_data", req1_if.rsp_data, e_data);
        chk("rsp1_err", req1_if.rsp_err, e_err);
      end
    end
  end

  task automatic wait_accept(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (act && (t_T == cyc)) done = 1'b1;
    end
    if (!done) bound_fail({nm, "_accept"});
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 400 && act; i++) step();
    if (act) bound_fail({nm, "_idle"});
  endtask

  // One directed command; latency is measured on the DUT response
  task automatic run_one(input int k, input logic [2:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input int L, input int D, input logic [RES_W-1:0] res,
                         input int exp_lat, input string nm);
    int lat;
    pv[k] = 1'b1; pop[k] = op; pa[k] = a; pb[k] = b;
    plan_L = L; plan_D = D; plan_res = res; rr[k] = 1'b1;
    wait_accept(nm);
    lat = -1;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      step();
      if (((k == 0) ? req0_if.rsp_valid : req1_if.rsp_valid) === 1'b1) lat = cyc - t_T;
    end
    chk({nm, "_latency"}, RES_W'(lat), RES_W'(exp_lat));
    wait_idle(nm);
  endtask

  initial begin
    logic [4:0] gs;
    bit         seen;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      pop[k] = '0; pa[k] = '0; pb[k] = '0; rr[k] = 1'b1;
    end
    plan_L = 0; plan_D = 0; plan_res = '0;
    t_nores = 1'b0; t_S = NEVER; t_g = NEVER; t_L = 0; t_D = 0; t_res = '0;
    t_data = '0; t_err = 1'b0; own = 0; t_T = 0;

    // Reset state
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_rsp0_valid", req0_if.rsp_valid, 1'b0);
    chk("reset_eng_start", eng_start, 1'b0);
    rst = 1'b0;
    step();

    // Single command with busy for 3 cycles: response 7 cycles after handshake
    run_one(0, 3'd0, 24'h001000, 24'h002000, 3, 0, 72'h123456, 7, "single");
    chk("single_eng_a", eng_a, 24'h001000);
    chk("single_eng_b", eng_b, 24'h002000);

    // No-result op: response two cycles after handshake, no get
    run_one(1, NORES, 24'h000abc, 24'h000def, 0, 0, 72'hdead, 2, "nores");

    // Engine stuck busy: error response 8 cycles after entering WAIT
    run_one(0, 3'd1, 24'h111111, 24'h222222, 1000, 0, 72'h55, 10, "timeout");

    // Next request is handled normally at minimum latency
    run_one(1, 3'd2, 24'h333333, 24'h444444, 0, 0, 72'hfeed_beef_cafe, 5, "minlat");

    // Response back-pressure: held 10 cycles while req1 waits
    rr[0] = 1'b0;
    pv[0] = 1'b1; pop[0] = 3'd2; pa[0] = 24'h0a0a0a; pb[0] = 24'h0b0b0b;
    plan_L = 1; plan_D = 1; plan_res = 72'h0102030405060708;
    wait_accept("hold");
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (req0_if.rsp_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) bound_fail("hold_rsp");
    pv[1] = 1'b1; pop[1] = 3'd4; pa[1] = 24'h0c0c0c; pb[1] = 24'h0d0d0d;
    plan_L = 0; plan_D = 0; plan_res = 72'h77;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_req1_ready", req1_if.ready, 1'b0);
      chk("hold_rsp0_data", req0_if.rsp_data, 72'h0102030405060708);
    end
    rr[0] = 1'b1;
    step();
    step();
    chk("post_hold_req1_ready", req1_if.ready, 1'b1);
    wait_idle("post_hold");

    // Asynchronous reset in the middle of WAIT
    pv[0] = 1'b1; pop[0] = 3'd3; pa[0] = 24'h123123; pb[0] = 24'h321321;
    plan_L = 1000; plan_D = 0; plan_res = 72'h99;
    wait_accept("rstw");
    step();
    step();
    step();
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_eng_start", eng_start, 1'b0);
    chk("arst_eng_get", eng_get, 1'b0);
    chk("arst_rsp0_valid", req0_if.rsp_valid, 1'b0);
    chk("arst_rsp1_valid", req1_if.rsp_valid, 1'b0);
    chk("arst_rsp_data", req0_if.rsp_data, 72'h0);
    chk("arst_rsp_err", req0_if.rsp_err, 1'b0);
    chk("arst_eng_op", eng_op, 3'd0);
    chk("arst_eng_a", eng_a, 24'h0);
    chk("arst_req0_ready", req0_if.ready, 1'b0);
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // After reset: a lone req1, then continuous contention
    grants.delete();
    pv[1] = 1'b1; pop[1] = 3'd1; pa[1] = 24'h000001; pb[1] = 24'h000002;
    plan_L = 0; plan_D = 1; plan_res = 72'h1;
    wait_accept("solo1");
    for (int i = 0; i < 300 && grants.size() < 5; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pv[k]) begin
          pv[k] = 1'b1; pop[k] = 3'($urandom_range(0, 6));
          pa[k] = DATA_W'($urandom); pb[k] = DATA_W'($urandom);
        end
      end
      plan_L = $urandom_range(0, 4); plan_D = $urandom_range(0, 2);
      plan_res = RES_W'({$urandom, $urandom, $urandom});
      step();
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    wait_idle("contention");
    gs = '0;
    for (int i = 0; i < 5 && i < grants.size(); i++) gs[4-i] = grants[i][0];
    chk("grant_order", gs, 5'b10101);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pv[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            pv[k] = 1'b1; pop[k] = 3'($urandom_range(0, 7));
            pa[k] = DATA_W'($urandom); pb[k] = DATA_W'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pv[k] = 1'b0;
        end
        rr[k] = ($urandom_range(0, 2) != 0);
      end
      plan_L   = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 9));
      plan_D   = $urandom_range(0, 4);
      plan_res = RES_W'({$urandom, $urandom, $urandom});
      step();
    end
    pv[0] = 1'b0; pv[1] = 1'b0; rr[0] = 1'b1; rr[1] = 1'b1;
    wait_idle("drain");
    step();

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
`default_nettype wire
